// File: rtl/segscan_pkg.sv
// Shared constants for the segment-bus scan decoder: active-low segment patterns
// (bit6..bit0 = top, upper-right, lower-right, bottom, lower-left, upper-left, middle).
package segscan_pkg;

   localparam logic [6:0] SEG_PAT_0     = 7'b0000001;
   localparam logic [6:0] SEG_PAT_1     = 7'b1001111;
   localparam logic [6:0] SEG_PAT_2     = 7'b0010010;
   localparam logic [6:0] SEG_PAT_3     = 7'b0000110;
   localparam logic [6:0] SEG_PAT_4     = 7'b1001100;
   localparam logic [6:0] SEG_PAT_5     = 7'b0100100;
   localparam logic [6:0] SEG_PAT_6     = 7'b0100000;
   localparam logic [6:0] SEG_PAT_7     = 7'b0001111;
   localparam logic [6:0] SEG_PAT_8     = 7'b0000000;
   localparam logic [6:0] SEG_PAT_9     = 7'b0001100;
   localparam logic [6:0] SEG_PAT_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_BLANK   = 4'hF;
   localparam logic [3:0] CODE_INVALID = 4'hE;

   typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational lookup from an active-low 7-segment pattern to its 4-bit digit code.
module seg_pattern_decode
   import segscan_pkg::*;
(
   input  logic [6:0] pat,
   output logic [3:0] code
);

   always_comb begin
      code = CODE_INVALID;
      case (pat)
         SEG_PAT_0:     code = 4'd0;
         SEG_PAT_1:     code = 4'd1;
         SEG_PAT_2:     code = 4'd2;
         SEG_PAT_3:     code = 4'd3;
         SEG_PAT_4:     code = 4'd4;
         SEG_PAT_5:     code = 4'd5;
         SEG_PAT_6:     code = 4'd6;
         SEG_PAT_7:     code = 4'd7;
         SEG_PAT_8:     code = 4'd8;
         SEG_PAT_9:     code = 4'd9;
         SEG_PAT_BLANK: code = CODE_BLANK;
         default:       code = CODE_INVALID;
      endcase
   end

endmodule

// File: rtl/segments_scan_decoder.sv
// Recovers per-digit codes from a multiplexed common-anode segment bus and publishes
// snapshots via valid/ready. Define SEGSCAN_DP_CAPTURE_EN to also capture decimal points.
module segments_scan_decoder
   import segscan_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned STABLE_CNT = 4,
   parameter int unsigned CNT_W      = $clog2(STABLE_CNT + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_sel_n,
   output logic [4*NUM_DIGITS-1:0] frame_digits,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic [7:0]              sel_err_cnt
`ifdef SEGSCAN_DP_CAPTURE_EN
   ,
   output logic [NUM_DIGITS-1:0]   frame_dp
`endif
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [NUM_DIGITS-1:0]   sel;
   logic                    sel_idle, sel_one, sel_err;
   logic [IDX_W-1:0]        sel_idx;
   logic [3:0]              dec_code;
   logic                    dp_in;
   logic                    same_key;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        cur_idx_q, cur_idx_d;
   logic [3:0]              cur_code_q, cur_code_d;
   logic                    cur_dp_q, cur_dp_d;
   logic [CNT_W-1:0]        stab_cnt_q, stab_cnt_d;
   logic [4*NUM_DIGITS-1:0] live_q, live_d;
   logic [NUM_DIGITS-1:0]   live_dp_q, live_dp_d;
   logic                    dirty_q, dirty_d;
   logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
   logic [NUM_DIGITS-1:0]   frame_dp_q, frame_dp_d;
   logic                    valid_q, valid_d;
   logic [7:0]              err_cnt_q, err_cnt_d;
   logic                    commit, commit_chg, load, load_frame;

   assign sel      = ~dig_sel_n;
   assign sel_idle = (sel == '0);
   assign sel_one  = !sel_idle && ((sel & (sel - NUM_DIGITS'(1))) == '0);
   assign sel_err  = !sel_idle && !sel_one;

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel[i]) sel_idx = IDX_W'(i);
      end
   end

   seg_pattern_decode u_decode (
      .pat  (seg_in[7:1]),
      .code (dec_code)
   );

   // Without DP capture the DP line is tied to a constant so it never affects tracking.
`ifdef SEGSCAN_DP_CAPTURE_EN
   assign dp_in = ~seg_in[0];
`else
   logic unused_dp;
   assign unused_dp = seg_in[0];
   assign dp_in     = 1'b0;
`endif

   assign same_key = (sel_idx == cur_idx_q) && (dec_code == cur_code_q) && (dp_in == cur_dp_q);

   always_comb begin
      state_d    = state_q;
      cur_idx_d  = cur_idx_q;
      cur_code_d = cur_code_q;
      cur_dp_d   = cur_dp_q;
      stab_cnt_d = stab_cnt_q;
      commit     = 1'b0;
      load       = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel_one) load = 1'b1;
         end
         TRACK: begin
            if (!sel_one) begin
               state_d    = IDLE;
               stab_cnt_d = '0;
            end else if (same_key) begin
               stab_cnt_d = stab_cnt_q + CNT_W'(1);
               if (stab_cnt_d == CNT_W'(STABLE_CNT)) begin
                  commit  = 1'b1;
                  state_d = LOCKED;
               end
            end else begin
               load = 1'b1;
            end
         end
         LOCKED: begin
            if (!sel_one) begin
               state_d    = IDLE;
               stab_cnt_d = '0;
            end else if (!same_key) begin
               load = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A fresh sample is itself the first stable sample; with STABLE_CNT=1 it commits now.
      if (load) begin
         cur_idx_d  = sel_idx;
         cur_code_d = dec_code;
         cur_dp_d   = dp_in;
         stab_cnt_d = CNT_W'(1);
         if (STABLE_CNT == 1) begin
            commit  = 1'b1;
            state_d = LOCKED;
         end else begin
            state_d = TRACK;
         end
      end
   end

   always_comb begin
      live_d     = live_q;
      live_dp_d  = live_dp_q;
      commit_chg = 1'b0;
      if (commit) begin
         commit_chg = (live_q[cur_idx_d*4 +: 4] != cur_code_d) || (live_dp_q[cur_idx_d] != cur_dp_d);
         live_d[cur_idx_d*4 +: 4] = cur_code_d;
         live_dp_d[cur_idx_d]     = cur_dp_d;
      end
   end

   always_comb begin
      load_frame = !valid_q && dirty_q;
      valid_d    = valid_q ? !frame_ready : dirty_q;
      dirty_d    = commit_chg || (dirty_q && !load_frame);
      frame_d    = load_frame ? live_q : frame_q;
      frame_dp_d = load_frame ? live_dp_q : frame_dp_q;
      err_cnt_d  = (sel_err && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cur_idx_q  <= '0;
         cur_code_q <= CODE_BLANK;
         cur_dp_q   <= 1'b0;
         stab_cnt_q <= '0;
         live_q     <= '1;
         live_dp_q  <= '0;
         dirty_q    <= 1'b0;
         frame_q    <= '1;
         frame_dp_q <= '0;
         valid_q    <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cur_idx_q  <= cur_idx_d;
         cur_code_q <= cur_code_d;
         cur_dp_q   <= cur_dp_d;
         stab_cnt_q <= stab_cnt_d;
         live_q     <= live_d;
         live_dp_q  <= live_dp_d;
         dirty_q    <= dirty_d;
         frame_q    <= frame_d;
         frame_dp_q <= frame_dp_d;
         valid_q    <= valid_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign frame_digits = frame_q;
   assign frame_valid  = valid_q;
   assign sel_err_cnt  = err_cnt_q;
`ifdef SEGSCAN_DP_CAPTURE_EN
   assign frame_dp     = frame_dp_q;
`else
   logic [NUM_DIGITS-1:0] unused_frame_dp;
   assign unused_frame_dp = frame_dp_q;
`endif

endmodule

// File: tb/tb_segments_scan_decoder.sv
// Directed self-checking bench for segments_scan_decoder (default 8 digits, 4 stable samples).
module tb_segments_scan_decoder;

   localparam int unsigned N = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [7:0]     seg_in;
   logic [N-1:0]   dig_sel_n;
   logic [4*N-1:0] frame_digits;
   logic           frame_valid;
   logic           frame_ready;
   logic [7:0]     sel_err_cnt;
`ifdef SEGSCAN_DP_CAPTURE_EN
   logic [N-1:0]   frame_dp;
`endif

   int tests = 0;
   int fails = 0;
   bit seen_valid;

   always #5 clk = ~clk;

   segments_scan_decoder #(
      .NUM_DIGITS (N),
      .STABLE_CNT (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .seg_in       (seg_in),
      .dig_sel_n    (dig_sel_n),
      .frame_digits (frame_digits),
      .frame_valid  (frame_valid),
      .frame_ready  (frame_ready),
      .sel_err_cnt  (sel_err_cnt)
`ifdef SEGSCAN_DP_CAPTURE_EN
      ,
      .frame_dp     (frame_dp)
`endif
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Ticks while recording whether frame_valid was ever observed high.
   task automatic tick_watch(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (frame_valid) seen_valid = 1'b1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      seg_in      = 8'hFF;
      dig_sel_n   = '1;
      frame_ready = 1'b0;
      #12;
      check("rst_valid", 32'(frame_valid), 32'd0);
      check("rst_digits", frame_digits, 32'hFFFF_FFFF);
      check("rst_errcnt", 32'(sel_err_cnt), 32'd0);
      rst_n = 1'b1;

      seen_valid = 1'b0;
      tick_watch(20);
      check("idle_no_valid", 32'(seen_valid), 32'd0);
      check("idle_errcnt", 32'(sel_err_cnt), 32'd0);

      // Digit 0 shows "3" (DP lit, ignored).
      dig_sel_n = 8'hFE;
      seg_in    = 8'b00001100;
      tick(4);
      check("d0_valid_t1", 32'(frame_valid), 32'd0);
      tick(1);
      check("d0_valid_t2", 32'(frame_valid), 32'd1);
      check("d0_digits", frame_digits, 32'hFFFF_FFF3);

      // Digit 2 shows "7" while the consumer stalls.
      dig_sel_n = 8'hFB;
      seg_in    = 8'b00011111;
      tick(6);
      check("stall_valid", 32'(frame_valid), 32'd1);
      check("stall_held", frame_digits, 32'hFFFF_FFF3);
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      check("hs_drop", 32'(frame_valid), 32'd0);
      tick(1);
      check("hs_reload_valid", 32'(frame_valid), 32'd1);
      check("hs_reload_digits", frame_digits, 32'hFFFF_F7F3);
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      check("consume2", 32'(frame_valid), 32'd0);

      // Digit 1 alternates "5"/"6" every 3 cycles: never stable long enough.
      dig_sel_n  = 8'hFD;
      seen_valid = 1'b0;
      for (int r = 0; r < 6; r++) begin
         seg_in = (r % 2 == 0) ? 8'b01001001 : 8'b01000001;
         tick_watch(3);
      end
      dig_sel_n = '1;
      tick_watch(4);
      check("toggle_no_frame", 32'(seen_valid), 32'd0);

      // Two digits selected at once.
      dig_sel_n  = 8'hFC;
      seg_in     = 8'b00000001;
      seen_valid = 1'b0;
      tick_watch(10);
      check("err_cnt_10", 32'(sel_err_cnt), 32'd10);
      tick_watch(290);
      check("err_cnt_sat", 32'(sel_err_cnt), 32'd255);
      dig_sel_n = '1;
      tick_watch(4);
      check("err_no_frame", 32'(seen_valid), 32'd0);
      check("err_cnt_hold", 32'(sel_err_cnt), 32'd255);

      // Unrecognised pattern on digit 4 commits as invalid.
      dig_sel_n = 8'hEF;
      seg_in    = 8'b01010101;
      tick(4);
      check("ill_valid_t1", 32'(frame_valid), 32'd0);
      tick(1);
      check("ill_valid_t2", 32'(frame_valid), 32'd1);
      check("ill_digits", frame_digits, 32'hFFFE_F7F3);
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      check("ill_consume", 32'(frame_valid), 32'd0);
      dig_sel_n  = '1;
      tick(2);
      dig_sel_n  = 8'hEF;
      seen_valid = 1'b0;
      tick_watch(8);
      check("ill_recommit_no_frame", 32'(seen_valid), 32'd0);

      // Frame on digit 7, then reset while it is pending.
      dig_sel_n = 8'h7F;
      seg_in    = 8'b00000001;
      tick(5);
      check("d7_valid", 32'(frame_valid), 32'd1);
      check("d7_digits", frame_digits, 32'h8FFE_F7F3);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(frame_valid), 32'd0);
      check("midrst_digits", frame_digits, 32'hFFFF_FFFF);
      check("midrst_errcnt", 32'(sel_err_cnt), 32'd0);
      dig_sel_n = '1;
      #3;
      rst_n = 1'b1;
      tick(3);
      check("post_rst_valid", 32'(frame_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/segments_scan_decoder.md
Name: segments_scan_decoder

Overview:
- Receive-side counterpart of the team's 7-segment encoder. It watches a time-multiplexed, common-anode segment bus and its digit-select lines, and recovers the 4-bit value shown on each digit.
- Used for on-board loopback and self-check: encoder → display bus → this block → compare.
- Presents snapshots of all digits through a valid/ready handshake.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..16).
- STABLE_CNT, 4, consecutive identical samples required before a digit value is committed (≥1).
- CNT_W, $clog2(STABLE_CNT+1), derived width of the stability counter; not overridden.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  8  segment bus, active-low; bit7 top, bit6 upper-right, bit5 lower-right, bit4 bottom, bit3 lower-left, bit2 upper-left, bit1 middle, bit0 DP.
- dig_sel_n  in  NUM_DIGITS  active-low one-hot digit enable.
- frame_digits  out  4*NUM_DIGITS  snapshot; digit i occupies [4i+3:4i].
- frame_valid  out  1  snapshot available.
- frame_ready  in  1  consumer accepts snapshot.
- sel_err_cnt  out  8  saturating count of malformed select cycles.

Behaviour:
- Decode table (seg_in[7:1] → code); DP is ignored for decode.
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0001100→9.
  - 1111111→4'hF (blank).
  - Any other pattern→4'hE (invalid).
- A select is valid when exactly one dig_sel_n bit is 0.
  - All-ones: idle, not an error.
  - Two or more zeros: error. sel_err_cnt increments by 1 and saturates at 255.
- Tracker FSM (registered: cur_idx, cur_code, stab_cnt):
  - IDLE: on a valid select, load idx and code, stab_cnt=1, go to TRACK.
  - TRACK:
    - Same idx and same code: stab_cnt++.
    - When stab_cnt reaches STABLE_CNT, commit code into live[idx] and go to LOCKED.
    - Different idx or code: reload and restart at 1.
    - Idle or error select: go to IDLE.
  - LOCKED:
    - Same idx and same code: hold, no recommit.
    - Code change on the same idx, or a new idx: reload into TRACK with stab_cnt=1.
    - Idle or error select: go to IDLE.
  - STABLE_CNT=1: commit in the same cycle the sample is loaded (IDLE→LOCKED).
- dirty flag:
  - Set when a commit changes live[idx].
  - A commit of an unchanged value does not set it.
- Output register:
  - When frame_valid=0 and dirty=1: next cycle, load frame_digits from live, set frame_valid, clear dirty.
  - While frame_valid=1, frame_digits is held constant.
  - frame_valid falls on the cycle after frame_valid & frame_ready.
  - A commit during that handshake cycle sets dirty. The next snapshot loads one cycle after frame_valid drops.
- Latency: the last required stable sample at cycle t gives live updated at t+1 and frame_valid=1 at t+2 (output idle).
- Reset (async assert, sync deassert expected externally):
  - live all 4'hF, frame_digits all 4'hF.
  - frame_valid=0, dirty=0, sel_err_cnt=0, FSM=IDLE, stab_cnt=0.
  - A mid-snapshot reset drops frame_valid immediately.
- Select index width is $clog2(NUM_DIGITS), minimum 1.

Optional Feature:
- SEGSCAN_DP_CAPTURE_EN defined:
  - Adds output frame_dp [NUM_DIGITS-1:0], where bit i=1 means DP lit.
  - The DP bit is part of the stability compare (code plus DP must both match) and is committed with the code.
  - Resets to 0.
- Undefined: port absent; DP is ignored entirely.

Decomposition:
- Package segscan_pkg:
  - 7-bit pattern localparams SEG_PAT_0..SEG_PAT_9 and SEG_PAT_BLANK.
  - Code constants CODE_BLANK=4'hF, CODE_INVALID=4'hE.
  - FSM state enum {IDLE, TRACK, LOCKED}.
- Sub-module seg_pattern_decode: combinational 7-bit→4-bit lookup, instantiated once in front of the tracker.

Test Plan:
- Reset release, dig_sel_n all-ones for 20 cycles → frame_valid stays 0, sel_err_cnt=0.
- dig_sel_n=8'hFE, seg_in=8'b00001100 ("3") held 4 cycles → frame_valid rises 2 cycles after the 4th sample; digit0=3, others 4'hF.
- Hold frame_ready=0, then drive digit2 with "7" for 4 cycles → frame_digits unchanged until ready. After the handshake, the next frame shows digit2=7, digit0=3.
- Digit1 pattern toggles "5"/"6" every 3 cycles → digit1 is never committed and no new frame is produced.
- dig_sel_n=8'hFC for 300 cycles → sel_err_cnt saturates at 255 and no commits occur.
- Illegal pattern 8'b01010101 stable for 4 cycles on digit4 → digit4=4'hE. Reasserting the same pattern afterwards produces no new frame.
